// File: rtl/line_drawer.sv
// line_drawer: rasterises one line segment per request into a stream of
// pixel writes using integer Bresenham stepping. Points outside the active
// area are walked through but never presented on the pixel port.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready high, waiting for start; endpoints latched on start
// SETUP | one cycle: deltas, step directions and initial error computed
// PLOT  | walk the line; on-screen points wait for pixel_ready
module line_drawer #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int X_WIDTH           = $clog2(HOR_ACTIVE_PIXELS),
  parameter int Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic               ready,
  input  logic [X_WIDTH-1:0] x1,
  input  logic [Y_WIDTH-1:0] y1,
  input  logic [X_WIDTH-1:0] x2,
  input  logic [Y_WIDTH-1:0] y2,
  output logic [X_WIDTH-1:0] pixel_x,
  output logic [Y_WIDTH-1:0] pixel_y,
  output logic               pixel_valid,
  input  logic               pixel_ready
);

  // Signed working width: one extra bit for the sign of a coordinate
  // difference and headroom for 2*err.
  localparam int W = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_PLOT  = 2'd2;

  localparam logic signed [W-1:0] ZERO_W = '0;

  logic [1:0]          r_state;
  logic [X_WIDTH-1:0]  r_x1, r_x2, r_cx;
  logic [Y_WIDTH-1:0]  r_y1, r_y2, r_cy;
  logic signed [W-1:0] r_dx, r_dy, r_err;
  logic                r_sx_neg, r_sy_neg;

  logic signed [W-1:0] w_x1_s, w_x2_s, w_y1_s, w_y2_s;
  logic signed [W-1:0] w_ddx, w_ddy, w_dx_abs, w_dy_neg;
  logic signed [W-1:0] w_e2, w_add_x, w_add_y, w_err_next;
  logic                w_step_x, w_step_y;
  logic                w_on_screen, w_advance, w_at_end;
  logic [X_WIDTH-1:0]  w_cx_next;
  logic [Y_WIDTH-1:0]  w_cy_next;

  // Zero-extend the latched endpoints into the signed working width.
  assign w_x1_s = {{(W-X_WIDTH){1'b0}}, r_x1};
  assign w_x2_s = {{(W-X_WIDTH){1'b0}}, r_x2};
  assign w_y1_s = {{(W-Y_WIDTH){1'b0}}, r_y1};
  assign w_y2_s = {{(W-Y_WIDTH){1'b0}}, r_y2};

  assign w_ddx    = w_x2_s - w_x1_s;
  assign w_ddy    = w_y2_s - w_y1_s;
  assign w_dx_abs = w_ddx[W-1] ? -w_ddx : w_ddx;
  // dy is kept as the negated magnitude, as the error update expects.
  assign w_dy_neg = w_ddy[W-1] ? w_ddy : -w_ddy;

  // Bresenham step decision for the current point.
  assign w_e2       = r_err <<< 1;
  assign w_step_x   = (w_e2 >= r_dy);
  assign w_step_y   = (w_e2 <= r_dx);
  assign w_add_x    = w_step_x ? r_dy : ZERO_W;
  assign w_add_y    = w_step_y ? r_dx : ZERO_W;
  assign w_err_next = r_err + w_add_x + w_add_y;

  // Stepping never leaves the segment, so the input widths cannot wrap.
  assign w_cx_next = !w_step_x ? r_cx :
                     (r_sx_neg ? r_cx - X_WIDTH'(1) : r_cx + X_WIDTH'(1));
  assign w_cy_next = !w_step_y ? r_cy :
                     (r_sy_neg ? r_cy - Y_WIDTH'(1) : r_cy + Y_WIDTH'(1));

  assign w_on_screen = (r_cx < X_WIDTH'(HOR_ACTIVE_PIXELS)) &&
                       (r_cy < Y_WIDTH'(VER_ACTIVE_PIXELS));
  // Off-screen points advance without a handshake.
  assign w_advance   = (r_state == S_PLOT) && (!w_on_screen || pixel_ready);
  assign w_at_end    = (r_cx == r_x2) && (r_cy == r_y2);

  // Outputs decode straight from registered state so reset clears them at once.
  assign ready       = (r_state == S_IDLE);
  assign pixel_valid = (r_state == S_PLOT) && w_on_screen;
  assign pixel_x     = r_cx;
  assign pixel_y     = r_cy;

  // Controller state sequencing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) r_state <= S_SETUP;
        S_SETUP: r_state <= S_PLOT;
        S_PLOT:  if (w_advance && w_at_end) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Endpoint capture; only an accepted request touches these.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x1 <= '0;
      r_y1 <= '0;
      r_x2 <= '0;
      r_y2 <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_x1 <= x1;
      r_y1 <= y1;
      r_x2 <= x2;
      r_y2 <= y2;
    end
  end

  // Line constants, computed once per segment in SETUP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dx     <= '0;
      r_dy     <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
    end else if (r_state == S_SETUP) begin
      r_dx     <= w_dx_abs;
      r_dy     <= w_dy_neg;
      r_sx_neg <= !(r_x1 < r_x2);
      r_sy_neg <= !(r_y1 < r_y2);
    end
  end

  // Walking point and error term: loaded in SETUP, stepped on each advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cx  <= '0;
      r_cy  <= '0;
      r_err <= '0;
    end else if (r_state == S_SETUP) begin
      r_cx  <= r_x1;
      r_cy  <= r_y1;
      r_err <= w_dx_abs + w_dy_neg;
    end else if (w_advance && !w_at_end) begin
      r_cx  <= w_cx_next;
      r_cy  <= w_cy_next;
      r_err <= w_err_next;
    end
  end

endmodule
